// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions for the encryptor and decryptor: FSM states,
// table size and key byte selection.
package arc4_pkg;

  localparam int unsigned KEY_W  = 24;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned S_SIZE = 256;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA_READ_I,
    ST_KSA_WAIT_I,
    ST_KSA_READ_J,
    ST_KSA_WAIT_J,
    ST_KSA_WRITE_I,
    ST_KSA_WRITE_J,
    ST_LEN_READ,
    ST_LEN_WAIT,
    ST_LEN_WRITE,
    ST_PRGA_READ_I,
    ST_PRGA_WAIT_I,
    ST_PRGA_READ_J,
    ST_PRGA_WAIT_J,
    ST_PRGA_WRITE_I,
    ST_PRGA_WRITE_J,
    ST_PRGA_READ_P,
    ST_PRGA_WAIT_P,
    ST_PRGA_WRITE_C,
    ST_DONE
  } state_t;

  // Key byte 0 is the most significant byte of the key.
  function automatic logic [BYTE_W-1:0] keybyte(input logic [KEY_W-1:0] key,
                                                input logic [1:0]       idx);
    logic [BYTE_W-1:0] kb;
    case (idx)
      2'd0:    kb = key[23:16];
      2'd1:    kb = key[15:8];
      default: kb = key[7:0];
    endcase
    return kb;
  endfunction

endpackage

// File: rtl/arc4_enc.sv
// Streaming ARC4 encryptor: reads a length-prefixed plaintext, keys ARC4 with
// a 24-bit key using an external 256x8 S memory, writes length-prefixed ciphertext.
module arc4_enc
  import arc4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  input  logic [KEY_W-1:0]  key,
  output logic [BYTE_W-1:0] pt_addr,
  input  logic [BYTE_W-1:0] pt_rddata,
  output logic [BYTE_W-1:0] ct_addr,
  output logic [BYTE_W-1:0] ct_wrdata,
  output logic              ct_wren,
  output logic [BYTE_W-1:0] s_addr,
  output logic [BYTE_W-1:0] s_wrdata,
  output logic              s_wren,
  input  logic [BYTE_W-1:0] s_rddata
);

  localparam logic [BYTE_W-1:0] LAST_IDX = BYTE_W'(S_SIZE - 1);

  state_t            state;
  logic [KEY_W-1:0]  key_q;
  logic [BYTE_W-1:0] i;
  logic [BYTE_W-1:0] j;
  logic [BYTE_W-1:0] k;
  logic [BYTE_W-1:0] len;
  logic [BYTE_W-1:0] si;
  logic [BYTE_W-1:0] sj;
  logic [BYTE_W-1:0] ptb;
  logic [1:0]        k3;

  logic [BYTE_W-1:0] i_inc_c;
  logic [BYTE_W-1:0] ksa_j_c;
  logic [BYTE_W-1:0] prga_j_c;
  logic [BYTE_W-1:0] pad_idx_c;

  // Index arithmetic, all modulo 256.
  assign i_inc_c   = BYTE_W'(i + 8'd1);
  assign ksa_j_c   = BYTE_W'(j + s_rddata + keybyte(key_q, k3));
  assign prga_j_c  = BYTE_W'(j + s_rddata);
  assign pad_idx_c = BYTE_W'(si + sj);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rdy       <= 1'b0;
      key_q     <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      len       <= '0;
      si        <= '0;
      sj        <= '0;
      ptb       <= '0;
      k3        <= '0;
      pt_addr   <= '0;
      ct_addr   <= '0;
      ct_wrdata <= '0;
      ct_wren   <= 1'b0;
      s_addr    <= '0;
      s_wrdata  <= '0;
      s_wren    <= 1'b0;
    end else begin
      s_wren  <= 1'b0;
      ct_wren <= 1'b0;
      case (state)
        ST_IDLE: begin
          rdy <= 1'b1;
          if (en && rdy) begin
            key_q <= key;
            rdy   <= 1'b0;
            i     <= '0;
            state <= ST_INIT;
          end
        end

        ST_INIT: begin
          s_addr   <= i;
          s_wrdata <= i;
          s_wren   <= 1'b1;
          i        <= i_inc_c;
          if (i == LAST_IDX) begin
            j     <= '0;
            k3    <= '0;
            state <= ST_KSA_READ_I;
          end
        end

        ST_KSA_READ_I: begin
          s_addr <= i;
          state  <= ST_KSA_WAIT_I;
        end

        ST_KSA_WAIT_I: state <= ST_KSA_READ_J;

        ST_KSA_READ_J: begin
          si     <= s_rddata;
          j      <= ksa_j_c;
          s_addr <= ksa_j_c;
          state  <= ST_KSA_WAIT_J;
        end

        ST_KSA_WAIT_J: state <= ST_KSA_WRITE_I;

        ST_KSA_WRITE_I: begin
          s_addr   <= i;
          s_wrdata <= s_rddata;
          s_wren   <= 1'b1;
          state    <= ST_KSA_WRITE_J;
        end

        ST_KSA_WRITE_J: begin
          s_addr   <= j;
          s_wrdata <= si;
          s_wren   <= 1'b1;
          if (i == LAST_IDX) begin
            state <= ST_LEN_READ;
          end else begin
            i     <= i_inc_c;
            k3    <= (k3 == 2'd2) ? 2'd0 : 2'(k3 + 2'd1);
            state <= ST_KSA_READ_I;
          end
        end

        ST_LEN_READ: begin
          pt_addr <= '0;
          state   <= ST_LEN_WAIT;
        end

        ST_LEN_WAIT: state <= ST_LEN_WRITE;

        // Length byte is copied through; an empty message skips PRGA entirely.
        ST_LEN_WRITE: begin
          len       <= pt_rddata;
          ct_addr   <= '0;
          ct_wrdata <= pt_rddata;
          ct_wren   <= 1'b1;
          i         <= '0;
          j         <= '0;
          k         <= 8'd1;
          state     <= (pt_rddata == '0) ? ST_DONE : ST_PRGA_READ_I;
        end

        ST_PRGA_READ_I: begin
          i       <= i_inc_c;
          s_addr  <= i_inc_c;
          pt_addr <= k;
          state   <= ST_PRGA_WAIT_I;
        end

        ST_PRGA_WAIT_I: state <= ST_PRGA_READ_J;

        ST_PRGA_READ_J: begin
          si     <= s_rddata;
          ptb    <= pt_rddata;
          j      <= prga_j_c;
          s_addr <= prga_j_c;
          state  <= ST_PRGA_WAIT_J;
        end

        ST_PRGA_WAIT_J: state <= ST_PRGA_WRITE_I;

        ST_PRGA_WRITE_I: begin
          sj       <= s_rddata;
          s_addr   <= i;
          s_wrdata <= s_rddata;
          s_wren   <= 1'b1;
          state    <= ST_PRGA_WRITE_J;
        end

        ST_PRGA_WRITE_J: begin
          s_addr   <= j;
          s_wrdata <= si;
          s_wren   <= 1'b1;
          state    <= ST_PRGA_READ_P;
        end

        // Swapped values sum to the same index as the pre-swap pair.
        ST_PRGA_READ_P: begin
          s_addr <= pad_idx_c;
          state  <= ST_PRGA_WAIT_P;
        end

        ST_PRGA_WAIT_P: state <= ST_PRGA_WRITE_C;

        ST_PRGA_WRITE_C: begin
          ct_addr   <= k;
          ct_wrdata <= s_rddata ^ ptb;
          ct_wren   <= 1'b1;
          if (k == len) begin
            state <= ST_DONE;
          end else begin
            k     <= BYTE_W'(k + 8'd1);
            state <= ST_PRGA_READ_I;
          end
        end

        ST_DONE: begin
          rdy   <= 1'b1;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_enc.sv
// Directed bench for arc4_enc with behavioural pt/ct/S memories and a
// software ARC4 decryptor for loopback checks.
module tb_arc4_enc;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_wrdata;
  logic        ct_wren;
  logic [7:0]  s_addr;
  logic [7:0]  s_wrdata;
  logic        s_wren;
  logic [7:0]  s_rddata;

  logic [7:0]  pt_mem  [256];
  logic [7:0]  ct_mem  [256];
  logic [7:0]  s_mem   [256];
  logic [7:0]  ref_out [256];
  int          ct_writes;

  int checks;
  int errors;

  localparam logic [71:0] KV_PT = 72'h506C61696E74657874;
  localparam logic [71:0] KV_CT = 72'hBBF316E8D940AF0AD3;

  arc4_enc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren),
    .s_addr    (s_addr),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .s_rddata  (s_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories with one-cycle read latency.
  initial ct_writes = 0;
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (ct_wren) begin
      ct_mem[ct_addr] <= ct_wrdata;
      ct_writes       <= ct_writes + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren});
  endfunction

  task automatic start_run(input logic [23:0] k_in);
    @(negedge clk);
    key = k_in;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    key = ~k_in;
  endtask

  task automatic wait_rdy(input string tag, input int budget);
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(rdy), 64'(1));
  endtask

  task automatic load_known();
    pt_mem[0] = 8'd9;
    for (int b = 1; b <= 9; b++) pt_mem[b] = KV_PT[8*(9-b) +: 8];
  endtask

  task automatic load_pattern(input int n);
    pt_mem[0] = 8'(n);
    for (int b = 1; b < 256; b++) pt_mem[b] = 8'(b * 37 + 11);
  endtask

  task automatic check_known(input string tag);
    chk({tag, "_len"}, 64'(ct_mem[0]), 64'(8'd9));
    for (int b = 1; b <= 9; b++)
      chk($sformatf("%s_ct%0d", tag, b), 64'(ct_mem[b]), 64'(KV_CT[8*(9-b) +: 8]));
  endtask

  // Reference ARC4 decryption of ct_mem[1..n] into ref_out.
  task automatic sw_decrypt(input logic [23:0] k_in, input int n);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] ii, jj, t;
    kb[0] = k_in[23:16];
    kb[1] = k_in[15:8];
    kb[2] = k_in[7:0];
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    jj = 8'd0;
    for (int x = 0; x < 256; x++) begin
      jj = 8'(jj + s[x] + kb[x % 3]);
      t = s[x]; s[x] = s[jj]; s[jj] = t;
    end
    ii = 8'd0;
    jj = 8'd0;
    for (int x = 1; x <= n; x++) begin
      ii = 8'(ii + 8'd1);
      jj = 8'(jj + s[ii]);
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      ref_out[x] = ct_mem[x] ^ s[8'(s[ii] + s[jj])];
    end
  endtask

  initial begin
    int w0;
    int cnt;
    int n;
    int bad;
    bit found;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    key    = 24'h0;

    // Reset and first idle cycle.
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 64'(0));
    #2 rst_n = 1'b1;
    #1 chk("rdy_before_edge", 64'(rdy), 64'(0));
    @(negedge clk);
    chk("rdy_after_edge", 64'(rdy), 64'(1));
    chk("idle_outs", all_outs(), 64'({1'b1, 42'd0}));

    // INIT fill, ignored en, key changes while busy, known vector.
    load_known();
    w0 = ct_writes;
    start_run(24'h4B6579);
    chk("rdy_drop", 64'(rdy), 64'(0));
    cnt = 0;
    n = 0;
    while (cnt < 256 && n < 600) begin
      @(negedge clk);
      n++;
      if (s_wren) cnt++;
      if (n == 100) en = 1'b1;
      if (n == 101) begin
        en = 1'b0;
        chk("en_ignored", 64'(rdy), 64'(0));
      end
    end
    chk("init_writes", 64'(cnt), 64'(256));
    @(negedge clk);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== 8'(x)) bad++;
    chk("init_s_identity", 64'(bad), 64'(0));
    wait_rdy("known_done", 4000);
    chk("known_writes", 64'(ct_writes - w0), 64'(10));
    check_known("known");

    // Empty message.
    pt_mem[0] = 8'd0;
    w0 = ct_writes;
    start_run(24'h000018);
    wait_rdy("empty_done", 4000);
    chk("empty_writes", 64'(ct_writes - w0), 64'(1));
    chk("empty_ct0", 64'(ct_mem[0]), 64'(0));

    // Loopback, 73 bytes, then back-to-back with another key.
    load_pattern(73);
    start_run(24'h1E4600);
    wait_rdy("loop1_done", 4000);
    chk("loop1_len", 64'(ct_mem[0]), 64'(73));
    sw_decrypt(24'h1E4600, 73);
    for (int b = 1; b <= 73; b++)
      chk($sformatf("loop1_b%0d", b), 64'(ref_out[b]), 64'(pt_mem[b]));
    start_run(24'h000018);
    wait_rdy("loop2_done", 4000);
    sw_decrypt(24'h000018, 73);
    bad = 0;
    for (int b = 1; b <= 73; b++) if (ref_out[b] !== pt_mem[b]) bad++;
    chk("loop2_mismatches", 64'(bad), 64'(0));

    // Maximum length message.
    load_pattern(255);
    w0 = ct_writes;
    start_run(24'h1E4600);
    wait_rdy("max_done", 6000);
    chk("max_writes", 64'(ct_writes - w0), 64'(256));
    chk("max_len", 64'(ct_mem[0]), 64'(255));
    sw_decrypt(24'h1E4600, 255);
    bad = 0;
    for (int b = 1; b <= 255; b++) if (ref_out[b] !== pt_mem[b]) bad++;
    chk("max_mismatches", 64'(bad), 64'(0));

    // Reset while working on byte 5, then a clean rerun.
    load_known();
    start_run(24'h4B6579);
    found = 1'b0;
    n = 0;
    while (!found && n < 4000) begin
      @(negedge clk);
      n++;
      if (ct_wren && ct_addr == 8'd4) found = 1'b1;
    end
    chk("reached_k4", 64'(found), 64'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midreset_outs", all_outs(), 64'(0));
    w0 = ct_writes;
    repeat (3) @(negedge clk);
    chk("midreset_hold", all_outs(), 64'(0));
    chk("midreset_no_writes", 64'(ct_writes - w0), 64'(0));
    #2 rst_n = 1'b1;
    #1 chk("midreset_rdy_low", 64'(rdy), 64'(0));
    @(negedge clk);
    chk("midreset_rdy_high", 64'(rdy), 64'(1));
    start_run(24'h4B6579);
    wait_rdy("rerun_done", 4000);
    check_known("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
